xadc_drp_sequencer: RTL and testbench
=====================================

Name: xadc_drp_sequencer

Overview:
- Sequences XADC DRP reads for the fuzzy controller's two analog inputs.
- On each end-of-conversion it issues one DRP read, alternating between channel 0 (aux 3, address 0x13) and channel 1 (aux 11, address 0x1B).
- Captures the 12-bit result from DRP data[15:4] into v1/v2, with valid strobes, overrun detection and a DRP timeout.
- Sits between the XADC primitive and the fuzzification stage.

Parameters:
- CH0_ADDR, 7'h13: DRP address of channel 0; result goes to v1.
- CH1_ADDR, 7'h1B: DRP address of channel 1; result goes to v2.
- TIMEOUT, 64: maximum cycles in WAIT without drdy before aborting (range 2..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- eoc  in  1  XADC end-of-conversion pulse, 1 cycle
- den  out  1  DRP enable, single-cycle pulse
- dwe  out  1  DRP write enable, tied 0
- daddr  out  7  DRP address
- drdy  in  1  DRP data ready
- drp_do  in  16  DRP read data
- v1  out  12  channel 0 result
- v2  out  12  channel 1 result
- v1_valid  out  1  1-cycle pulse when v1 updates
- v2_valid  out  1  1-cycle pulse when v2 updates
- pair_valid  out  1  pulses with v2_valid when the preceding ch0 read in the same round succeeded
- busy  out  1  high when the FSM is not in IDLE
- overrun  out  1  sticky: eoc arrived while pending was already set
- timeout_err  out  1  sticky: DRP read timed out
- clr_err  in  1  synchronous clear of overrun and timeout_err

Behaviour:
- Reset values:
  - den, dwe, busy, all valid pulses, overrun, timeout_err = 0.
  - v1 = v2 = 0; daddr = CH0_ADDR; channel pointer ch = 0; pending = 0; timeout counter = 0; FSM = IDLE.
- FSM states: IDLE, REQ, WAIT, CAPT.
- IDLE:
  - If eoc or pending is set, go to REQ and clear pending.
  - daddr is driven to the selected channel's address on entry to REQ.
- REQ: den = 1 for exactly one cycle, daddr stable. Go to WAIT; timeout counter cleared.
- WAIT:
  - daddr held. On drdy = 1, register drp_do[15:4] into a capture register and go to CAPT.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without drdy: set timeout_err, do not advance ch, clear the round-ok flag, go to IDLE.
- CAPT:
  - If ch = 0: write v1, pulse v1_valid, set round-ok.
  - If ch = 1: write v2, pulse v2_valid; pulse pair_valid if round-ok, then clear round-ok.
  - Toggle ch. Go to REQ if pending, else IDLE.
- Latency: eoc at cycle N → den at N+1. drdy at cycle M → result and valid pulse visible at M+1.
- drdy in IDLE, REQ or CAPT is ignored.
- drdy on the same cycle as a timeout: drdy wins (captured, no error).
- eoc while busy sets pending. eoc while pending is already set sets overrun and is dropped (queue depth 1).
- eoc in the same cycle that IDLE consumes pending: that eoc sets pending again.
- clr_err and a new error event in the same cycle: the error wins (flag stays 1).
- dwe is constantly 0; the block never writes the DRP.
- Asynchronous rst mid-read: everything returns to reset values immediately, and a later stray drdy is ignored. v1/v2 are not preserved.

Optional Feature:
- Macro: XADC_SEQ_AVG_EN.
- Defined:
  - Each channel output is a 2-tap IIR: v <= (v + sample + 1) >> 1, using a 13-bit sum.
  - The first sample per channel after reset loads directly, tracked by per-channel first flags.
  - Valid pulses and timing are unchanged.
- Undefined: v <= sample directly; no extra registers.

Test Plan:
- Reset, then eoc; drdy 3 cycles after den with drp_do = 16'hABC0.
  - Expected: den at eoc+1 with daddr = 7'h13; v1 = 12'hABC with v1_valid pulse; ch = 1.
- Second eoc; drdy with drp_do = 16'h1230.
  - Expected: daddr = 7'h1B, v2 = 12'h123, v2_valid and pair_valid in the same cycle.
- eoc, then two more eocs while in WAIT.
  - Expected: overrun = 1; exactly one queued read, issued on CAPT→REQ with no IDLE cycle; clr_err clears overrun.
- eoc with no drdy.
  - Expected: timeout_err = 1 after 64 WAIT cycles; back in IDLE; next eoc re-reads daddr = 7'h13; the following ch1 capture gives no pair_valid.
- Assert rst while in WAIT, then release and apply a late drdy.
  - Expected: all outputs at reset values; no valid pulse; FSM in IDLE.
- With XADC_SEQ_AVG_EN defined, ch0 samples 0x100 then 0x201.
  - Expected: v1 = 0x100, then v1 = 0x181.

Source files
------------

// File: rtl/xadc_drp_sequencer.sv
// xadc_drp_sequencer: alternates XADC DRP reads between two aux channels on
// each end-of-conversion and hands 12-bit results to the fuzzification stage.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   eoc               XADC end-of-conversion pulse
//   den, dwe, daddr   DRP request (read only, dwe tied low)
//   drdy, drp_do      DRP response
//   v1, v2            channel 0 / channel 1 results
//   v1_valid,v2_valid result update strobes
//   pair_valid        ch1 update whose preceding ch0 read in the round succeeded
//   busy              FSM not idle
//   overrun           sticky: eoc dropped because one was already queued
//   timeout_err       sticky: DRP read never answered
//   clr_err           synchronous clear of the sticky flags
//
// Optional build macro XADC_SEQ_AVG_EN: each output becomes a 2-tap IIR
// v <= (v + sample + 1) >> 1, with the first sample per channel loaded as is.

module xadc_drp_sequencer #(
    parameter logic [6:0] CH0_ADDR = 7'h13,
    parameter logic [6:0] CH1_ADDR = 7'h1B,
    parameter int         TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        eoc,
    output logic        den,
    output logic        dwe,
    output logic [6:0]  daddr,
    input  logic        drdy,
    input  logic [15:0] drp_do,
    output logic [11:0] v1,
    output logic [11:0] v2,
    output logic        v1_valid,
    output logic        v2_valid,
    output logic        pair_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout_err,
    input  logic        clr_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        CAPT
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic        ch_q;
    logic        pend_q;
    logic        rok_q;
    logic [7:0]  cnt_q;
    logic        den_q;
    logic [6:0]  daddr_q;
    logic [11:0] v1_q;
    logic [11:0] v2_q;
    logic        v1_vld_q;
    logic        v2_vld_q;
    logic        pair_q;
    logic        busy_q;
    logic        ovr_q;
    logic        tmo_q;

    logic [11:0] samp;
    logic [11:0] v1_d;
    logic [11:0] v2_d;
    logic [3:0]  unused_lsb;

    assign samp       = drp_do[15:4];
    assign unused_lsb = drp_do[3:0];

`ifdef XADC_SEQ_AVG_EN
    logic        first1_q;
    logic        first2_q;
    logic [12:0] sum1;
    logic [12:0] sum2;

    assign sum1 = {1'b0, v1_q} + {1'b0, samp} + 13'd1;
    assign sum2 = {1'b0, v2_q} + {1'b0, samp} + 13'd1;
    assign v1_d = first1_q ? samp : sum1[12:1];
    assign v2_d = first2_q ? samp : sum2[12:1];
`else
    assign v1_d = samp;
    assign v2_d = samp;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= 1'b0;
            pend_q   <= 1'b0;
            rok_q    <= 1'b0;
            cnt_q    <= '0;
            den_q    <= 1'b0;
            daddr_q  <= CH0_ADDR;
            v1_q     <= '0;
            v2_q     <= '0;
            v1_vld_q <= 1'b0;
            v2_vld_q <= 1'b0;
            pair_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            tmo_q    <= 1'b0;
`ifdef XADC_SEQ_AVG_EN
            first1_q <= 1'b1;
            first2_q <= 1'b1;
`endif
        end else begin
            den_q    <= 1'b0;
            v1_vld_q <= 1'b0;
            v2_vld_q <= 1'b0;
            pair_q   <= 1'b0;

            // Clear first so a same-cycle error event below overrides it.
            if (clr_err) begin
                ovr_q <= 1'b0;
                tmo_q <= 1'b0;
            end

            // One-deep eoc queue. IDLE and CAPT consume pending this cycle,
            // so an eoc arriving then simply re-queues instead of overrunning.
            unique case (state_q)
                IDLE: pend_q <= pend_q & eoc;
                CAPT: pend_q <= eoc;
                default: begin
                    if (eoc) begin
                        if (pend_q) ovr_q  <= 1'b1;
                        else        pend_q <= 1'b1;
                    end
                end
            endcase

            unique case (state_q)
                IDLE: begin
                    if (eoc || pend_q) begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        daddr_q <= ch_q ? CH1_ADDR : CH0_ADDR;
                    end
                end
                REQ: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    // Result is written on entry to CAPT so it appears
                    // the cycle after drdy; drdy beats a same-cycle timeout.
                    if (drdy) begin
                        state_q <= CAPT;
                        if (!ch_q) begin
                            v1_q     <= v1_d;
                            v1_vld_q <= 1'b1;
                            rok_q    <= 1'b1;
`ifdef XADC_SEQ_AVG_EN
                            first1_q <= 1'b0;
`endif
                        end else begin
                            v2_q     <= v2_d;
                            v2_vld_q <= 1'b1;
                            pair_q   <= rok_q;
                            rok_q    <= 1'b0;
`ifdef XADC_SEQ_AVG_EN
                            first2_q <= 1'b0;
`endif
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tmo_q   <= 1'b1;
                        rok_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                CAPT: begin
                    ch_q <= ~ch_q;
                    if (pend_q) begin
                        state_q <= REQ;
                        den_q   <= 1'b1;
                        daddr_q <= ch_q ? CH0_ADDR : CH1_ADDR;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign den         = den_q;
    assign dwe         = 1'b0;
    assign daddr       = daddr_q;
    assign v1          = v1_q;
    assign v2          = v2_q;
    assign v1_valid    = v1_vld_q;
    assign v2_valid    = v2_vld_q;
    assign pair_valid  = pair_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// tb_xadc_drp_sequencer: directed bench for xadc_drp_sequencer.
// Honours XADC_SEQ_AVG_EN when computing expected results.

module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        eoc = 1'b0;
    logic        den;
    logic        dwe;
    logic [6:0]  daddr;
    logic        drdy = 1'b0;
    logic [15:0] drp_do = '0;
    logic [11:0] v1;
    logic [11:0] v2;
    logic        v1_valid;
    logic        v2_valid;
    logic        pair_valid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic        clr_err = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] m_v1;
    logic [11:0] m_v2;
    logic        m_f1;
    logic        m_f2;

    always #5 clk = ~clk;

    xadc_drp_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .eoc         (eoc),
        .den         (den),
        .dwe         (dwe),
        .daddr       (daddr),
        .drdy        (drdy),
        .drp_do      (drp_do),
        .v1          (v1),
        .v2          (v2),
        .v1_valid    (v1_valid),
        .v2_valid    (v2_valid),
        .pair_valid  (pair_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] nxt(input logic [11:0] old,
                                        input logic [11:0] s,
                                        input logic first);
        logic [12:0] sm;
        sm = {1'b0, old} + {1'b0, s} + 13'd1;
`ifdef XADC_SEQ_AVG_EN
        return first ? s : sm[12:1];
`else
        return (first || sm[0] || !sm[0]) ? s : old;
`endif
    endfunction

    task automatic model_reset();
        m_v1 = '0;
        m_v2 = '0;
        m_f1 = 1'b1;
        m_f2 = 1'b1;
    endtask

    task automatic model_capt(input logic c1, input logic [15:0] d);
        if (!c1) begin
            m_v1 = nxt(m_v1, d[15:4], m_f1);
            m_f1 = 1'b0;
        end else begin
            m_v2 = nxt(m_v2, d[15:4], m_f2);
            m_f2 = 1'b0;
        end
    endtask

    // Full read: eoc, request check, drdy after one WAIT cycle, result check.
    task automatic rd(input string tag, input logic [6:0] a,
                      input logic [15:0] d, input logic c1,
                      input logic pair_exp);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check({tag, "_den"}, den, 1'b1);
        check({tag, "_addr"}, daddr, a);
        tick();
        tick();
        drdy   = 1'b1;
        drp_do = d;
        tick();
        drdy = 1'b0;
        model_capt(c1, d);
        if (!c1) begin
            check({tag, "_v1"}, v1, m_v1);
            check({tag, "_v1vld"}, v1_valid, 1'b1);
        end else begin
            check({tag, "_v2"}, v2, m_v2);
            check({tag, "_v2vld"}, v2_valid, 1'b1);
            check({tag, "_pair"}, pair_valid, pair_exp);
        end
        tick();
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        check("rst_den", den, 1'b0);
        check("rst_dwe", dwe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_daddr", daddr, 7'h13);
        check("rst_v1", v1, 12'h0);
        check("rst_v2", v2, 12'h0);
        check("rst_vld", {v1_valid, v2_valid, pair_valid}, 3'b000);
        check("rst_err", {overrun, timeout_err}, 2'b00);
        rst = 1'b0;
        tick();

        // First ch0 read, drdy three cycles after den.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t1_den", den, 1'b1);
        check("t1_addr", daddr, 7'h13);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_den_pulse", den, 1'b0);
        tick();
        tick();
        drdy   = 1'b1;
        drp_do = 16'hABC0;
        tick();
        drdy = 1'b0;
        model_capt(1'b0, 16'hABC0);
        check("t1_v1", v1, m_v1);
        check("t1_v1vld", v1_valid, 1'b1);
        check("t1_v2vld", v2_valid, 1'b0);
        tick();
        check("t1_v1vld_off", v1_valid, 1'b0);
        check("t1_idle", busy, 1'b0);

        // Ch1 read completes the pair.
        rd("t2", 7'h1B, 16'h1230, 1'b1, 1'b1);
        check("t2_v2_raw", v2, 12'h123);

        // Two extra eocs in WAIT: one queued, one dropped.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t3_addr", daddr, 7'h13);
        tick();
        eoc = 1'b1;
        tick();
        check("t3_no_ovr", overrun, 1'b0);
        tick();
        eoc = 1'b0;
        check("t3_ovr", overrun, 1'b1);
        drdy   = 1'b1;
        drp_do = 16'h5550;
        tick();
        drdy = 1'b0;
        model_capt(1'b0, 16'h5550);
        check("t3_v1", v1, m_v1);
        tick();
        check("t3_q_den", den, 1'b1);
        check("t3_q_addr", daddr, 7'h1B);
        check("t3_q_busy", busy, 1'b1);
        tick();
        drdy   = 1'b1;
        drp_do = 16'h7770;
        tick();
        drdy = 1'b0;
        model_capt(1'b1, 16'h7770);
        check("t3_v2", v2, m_v2);
        check("t3_pair", pair_valid, 1'b1);
        tick();
        check("t3_idle", busy, 1'b0);
        check("t3_ovr_sticky", overrun, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_ovr_clr", overrun, 1'b0);

        // Ch0 timeout at the 64th WAIT cycle.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t4_addr", daddr, 7'h13);
        tick();
        repeat (63) tick();
        check("t4_pre_tmo", timeout_err, 1'b0);
        check("t4_pre_busy", busy, 1'b1);
        tick();
        check("t4_tmo", timeout_err, 1'b1);
        check("t4_idle", busy, 1'b0);
        check("t4_v1vld", v1_valid, 1'b0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t4_tmo_clr", timeout_err, 1'b0);

        // Channel not advanced; drdy on the last WAIT cycle beats timeout.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t5_addr", daddr, 7'h13);
        tick();
        repeat (63) tick();
        drdy   = 1'b1;
        drp_do = 16'h2340;
        tick();
        drdy = 1'b0;
        model_capt(1'b0, 16'h2340);
        check("t5_v1", v1, m_v1);
        check("t5_v1vld", v1_valid, 1'b1);
        check("t5_no_tmo", timeout_err, 1'b0);
        tick();

        // Ch1 timeout coinciding with clr_err: error wins.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        check("t6_addr", daddr, 7'h1B);
        tick();
        repeat (63) tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t6_tmo", timeout_err, 1'b1);
        check("t6_idle", busy, 1'b0);

        // Retry of ch1: round broken by the timeout, so no pair.
        rd("t7", 7'h1B, 16'h9990, 1'b1, 1'b0);

        // Asynchronous reset in WAIT, then a stray drdy.
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t8_den", den, 1'b0);
        check("t8_busy", busy, 1'b0);
        check("t8_daddr", daddr, 7'h13);
        check("t8_v1", v1, 12'h0);
        check("t8_v2", v2, 12'h0);
        check("t8_err", {overrun, timeout_err}, 2'b00);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        drdy   = 1'b1;
        drp_do = 16'hFFF0;
        tick();
        drdy = 1'b0;
        check("t8_no_vld", {v1_valid, v2_valid, pair_valid}, 3'b000);
        check("t8_v1_hold", v1, 12'h0);
        check("t8_idle", busy, 1'b0);
        tick();

        // Two ch0 samples after reset; averaged when the macro is set.
        rd("t9a", 7'h13, 16'h1000, 1'b0, 1'b0);
        check("t9_first", v1, 12'h100);
        rd("t9b", 7'h1B, 16'h0500, 1'b1, 1'b1);
        rd("t9c", 7'h13, 16'h2010, 1'b0, 1'b0);
`ifdef XADC_SEQ_AVG_EN
        check("t9_avg", v1, 12'h181);
`else
        check("t9_raw", v1, 12'h201);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
